// File: rtl/vga_pattern_gen.sv
// Test-pattern pixel source placed directly after a VGA sync generator.
// Two-stage pipeline: stage1 registers the sync/DE/X/Y inputs, and stage2 computes
// the colour and registers every output. Syncs, DE and RGB all leave exactly
// 2 clocks after entering, so they stay aligned.
// The pattern mode, frame counter and bouncing box update at frame start, which is
// the falling edge of the stage1 vertical sync.
module vga_pattern_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int COLOR_W   = 4,
  parameter int CHK_SHIFT = 5,
  parameter int BOX_SIZE  = 32
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               iH_SYNC,
  input  logic               iV_SYNC,
  input  logic               iDE,
  input  logic [10:0]        iX,
  input  logic [10:0]        iY,
  input  logic [1:0]         iMODE,
  output logic               oH_SYNC,
  output logic               oV_SYNC,
  output logic               oDE,
  output logic [COLOR_W-1:0] oR,
  output logic [COLOR_W-1:0] oG,
  output logic [COLOR_W-1:0] oB,
  output logic [15:0]        oFRAME_CNT
);

  localparam logic [10:0]        BX_MAX = 11'(H_ACTIVE - BOX_SIZE);
  localparam logic [10:0]        BY_MAX = 11'(V_ACTIVE - BOX_SIZE);
  localparam int                 BAR_W  = H_ACTIVE / 8;
  localparam logic [COLOR_W-1:0] FULL   = {COLOR_W{1'b1}};

  // stage1 registers
  logic        r_hs1, r_vs1, r_de1, r_vs1_prev;
  logic [10:0] r_x1, r_y1;
  // frame-rate state
  logic [1:0]  r_mode;
  logic [15:0] r_frame_cnt;
  logic [10:0] r_bx, r_by;
  logic        r_dx_neg, r_dy_neg;

  logic               w_fs;
  logic [2:0]         w_bar;
  logic               w_chk;
  logic               w_in_box;
  logic [COLOR_W-1:0] w_r, w_g, w_b;
  logic [10:0]        w_bx_n, w_by_n;
  logic               w_dx_neg_n, w_dy_neg_n;

  assign w_fs       = r_vs1_prev & ~r_vs1;
  assign oFRAME_CNT = r_frame_cnt;

  // Stage1: register the raw sync-generator outputs plus the previous vsync value.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_hs1      <= 1'b1;
      r_vs1      <= 1'b1;
      r_vs1_prev <= 1'b1;
      r_de1      <= 1'b0;
      r_x1       <= '0;
      r_y1       <= '0;
    end else begin
      r_hs1      <= iH_SYNC;
      r_vs1      <= iV_SYNC;
      r_vs1_prev <= r_vs1;
      r_de1      <= iDE;
      r_x1       <= iX;
      r_y1       <= iY;
    end
  end

  // Box step for both axes; a wall hit reverses the direction and steps away from it.
  always_comb begin
    w_bx_n     = r_dx_neg ? r_bx - 11'd1 : r_bx + 11'd1;
    w_dx_neg_n = r_dx_neg;
    if (!r_dx_neg && r_bx == BX_MAX) begin
      w_dx_neg_n = 1'b1;
      w_bx_n     = r_bx - 11'd1;
    end else if (r_dx_neg && r_bx == 11'd0) begin
      w_dx_neg_n = 1'b0;
      w_bx_n     = 11'd1;
    end
    w_by_n     = r_dy_neg ? r_by - 11'd1 : r_by + 11'd1;
    w_dy_neg_n = r_dy_neg;
    if (!r_dy_neg && r_by == BY_MAX) begin
      w_dy_neg_n = 1'b1;
      w_by_n     = r_by - 11'd1;
    end else if (r_dy_neg && r_by == 11'd0) begin
      w_dy_neg_n = 1'b0;
      w_by_n     = 11'd1;
    end
  end

  // Frame-start state: counter, latched mode and box position.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_frame_cnt <= '0;
      r_mode      <= 2'd0;
      r_bx        <= '0;
      r_by        <= '0;
      r_dx_neg    <= 1'b0;
      r_dy_neg    <= 1'b0;
    end else if (w_fs) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
      r_mode      <= iMODE;
      r_bx        <= w_bx_n;
      r_by        <= w_by_n;
      r_dx_neg    <= w_dx_neg_n;
      r_dy_neg    <= w_dy_neg_n;
    end
  end

  // Colour from the stage1 pixel; blanking always gives black.
  always_comb begin
    w_bar = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (int'(r_x1) >= k * BAR_W) w_bar = w_bar + 3'd1;
    end
    w_chk    = r_x1[CHK_SHIFT] ^ r_y1[CHK_SHIFT];
    w_in_box = ({1'b0, r_x1} >= {1'b0, r_bx}) && ({1'b0, r_x1} < {1'b0, r_bx} + 12'(BOX_SIZE)) &&
               ({1'b0, r_y1} >= {1'b0, r_by}) && ({1'b0, r_y1} < {1'b0, r_by} + 12'(BOX_SIZE));
    w_r = '0;
    w_g = '0;
    w_b = '0;
    if (r_de1) begin
      case (r_mode)
        2'd0: begin
          w_r = w_bar[1] ? '0 : FULL;
          w_g = w_bar[2] ? '0 : FULL;
          w_b = w_bar[0] ? '0 : FULL;
        end
        2'd1: begin
          w_r = w_chk ? '0 : FULL;
          w_g = w_chk ? '0 : FULL;
          w_b = w_chk ? '0 : FULL;
        end
        2'd2: begin
          w_r = w_in_box ? FULL : '0;
          w_g = w_in_box ? FULL : '0;
          w_b = FULL;
        end
        default: begin
          w_r = r_x1[7:8-COLOR_W];
          w_g = r_y1[7:8-COLOR_W];
          w_b = r_frame_cnt[7:8-COLOR_W];
        end
      endcase
    end
  end

  // Stage2: register every output together so they stay aligned.
  always_ff @(posedge CLK) begin
    if (RST) begin
      oH_SYNC <= 1'b1;
      oV_SYNC <= 1'b1;
      oDE     <= 1'b0;
      oR      <= '0;
      oG      <= '0;
      oB      <= '0;
    end else begin
      oH_SYNC <= r_hs1;
      oV_SYNC <= r_vs1;
      oDE     <= r_de1;
      oR      <= w_r;
      oG      <= w_g;
      oB      <= w_b;
    end
  end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed self-checking bench for vga_pattern_gen (default parameters, COLOR_W=4).
module tb_vga_pattern_gen;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iH_SYNC, iV_SYNC, iDE;
  logic [10:0] iX, iY;
  logic [1:0]  iMODE;
  logic        oH_SYNC, oV_SYNC, oDE;
  logic [3:0]  oR, oG, oB;
  logic [15:0] oFRAME_CNT;

  int n_vec = 0;
  int n_err = 0;

  vga_pattern_gen dut (
    .CLK        (CLK),
    .RST        (RST),
    .iH_SYNC    (iH_SYNC),
    .iV_SYNC    (iV_SYNC),
    .iDE        (iDE),
    .iX         (iX),
    .iY         (iY),
    .iMODE      (iMODE),
    .oH_SYNC    (oH_SYNC),
    .oV_SYNC    (oV_SYNC),
    .oDE        (oDE),
    .oR         (oR),
    .oG         (oG),
    .oB         (oB),
    .oFRAME_CNT (oFRAME_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One active pixel through the pipe; colour checked 2 clocks later.
  task automatic pixel(input string tag, input int x, input int y, input logic [11:0] exp);
    iDE = 1'b1;
    iX  = 11'(x);
    iY  = 11'(y);
    tick();
    tick();
    check(tag, {20'd0, oR, oG, oB}, {20'd0, exp});
    iDE = 1'b0;
  endtask

  // Minimal frame: one-cycle vsync low pulse; counter updated when this returns.
  task automatic frame();
    iV_SYNC = 1'b0;
    tick();
    iV_SYNC = 1'b1;
    tick();
  endtask

  initial begin
    RST = 1'b1; iH_SYNC = 1'b1; iV_SYNC = 1'b1; iDE = 1'b0;
    iX = '0; iY = '0; iMODE = 2'd0;

    // reset state
    tick(); tick(); tick();
    check("rst_hs",  {31'd0, oH_SYNC}, 32'd1);
    check("rst_vs",  {31'd0, oV_SYNC}, 32'd1);
    check("rst_de",  {31'd0, oDE}, 32'd0);
    check("rst_rgb", {20'd0, oR, oG, oB}, 32'd0);
    check("rst_cnt", {16'd0, oFRAME_CNT}, 32'd0);
    RST = 1'b0;
    tick(); tick();

    // latency: exactly 2 clocks for DE, RGB and syncs
    iDE = 1'b1; iX = 11'd5; iY = 11'd0; iH_SYNC = 1'b0;
    tick();
    check("lat1_de",  {31'd0, oDE}, 32'd0);
    check("lat1_hs",  {31'd0, oH_SYNC}, 32'd1);
    check("lat1_rgb", {20'd0, oR, oG, oB}, 32'd0);
    tick();
    check("lat2_de",  {31'd0, oDE}, 32'd1);
    check("lat2_hs",  {31'd0, oH_SYNC}, 32'd0);
    check("lat2_rgb", {20'd0, oR, oG, oB}, 32'hFFF);
    iH_SYNC = 1'b1; iDE = 1'b0;
    tick();
    check("lat3_hs", {31'd0, oH_SYNC}, 32'd0);
    tick();
    check("lat4_hs", {31'd0, oH_SYNC}, 32'd1);

    // colour bars
    pixel("bar_x0",   0,   0, 12'hFFF);
    pixel("bar_x80",  80,  0, 12'hFF0);
    pixel("bar_x160", 160, 0, 12'h0FF);
    pixel("bar_x320", 320, 0, 12'hF0F);
    pixel("bar_x400", 400, 0, 12'hF00);
    pixel("bar_x639", 639, 0, 12'h000);
    iDE = 1'b0; iX = 11'd0;
    tick(); tick();
    check("bar_blank", {20'd0, oR, oG, oB}, 32'd0);

    // mode change waits for the next frame start
    iMODE = 2'd1;
    pixel("mode_hold", 32, 0, 12'hFFF);
    frame();
    check("cnt_1", {16'd0, oFRAME_CNT}, 32'd1);
    pixel("chk_32_0",  32, 0,  12'h000);
    pixel("chk_32_32", 32, 32, 12'hFFF);
    pixel("chk_0_0",   0,  0,  12'hFFF);
    pixel("chk_0_32",  0,  32, 12'h000);

    // gradient
    iMODE = 2'd3;
    frame();
    check("cnt_2", {16'd0, oFRAME_CNT}, 32'd2);
    pixel("grad", 11'hAB, 11'h5C, 12'hA50);

    // bouncing box, counting from a fresh reset
    RST = 1'b1;
    tick();
    RST = 1'b0;
    iMODE = 2'd2;
    for (int i = 0; i < 448; i++) frame();
    check("cnt_448", {16'd0, oFRAME_CNT}, 32'd448);
    pixel("box448_in",   448, 448, 12'hFFF);
    pixel("box448_lx",   447, 448, 12'h00F);
    pixel("box448_ly",   448, 447, 12'h00F);
    pixel("box448_br",   479, 479, 12'hFFF);
    pixel("box448_rx",   480, 479, 12'h00F);
    for (int i = 0; i < 160; i++) frame();
    pixel("box608_in",   608, 288, 12'hFFF);
    pixel("box608_lx",   607, 288, 12'h00F);
    pixel("box608_br",   639, 319, 12'hFFF);
    pixel("box608_by",   608, 320, 12'h00F);
    frame();
    pixel("box609_in",   607, 287, 12'hFFF);
    pixel("box609_rx",   639, 287, 12'h00F);
    frame();
    check("cnt_610", {16'd0, oFRAME_CNT}, 32'd610);
    pixel("box610_in",   606, 286, 12'hFFF);
    pixel("box610_lx",   605, 286, 12'h00F);

    // frame counter wrap
    force dut.r_frame_cnt = 16'hFFFF;
    tick();
    release dut.r_frame_cnt;
    tick();
    check("cnt_ffff", {16'd0, oFRAME_CNT}, 32'h0000FFFF);
    frame();
    check("cnt_wrap", {16'd0, oFRAME_CNT}, 32'd0);

    // reset mid-line
    iMODE = 2'd0; frame();
    iDE = 1'b1; iX = 11'd0; iY = 11'd0; iH_SYNC = 1'b0;
    tick(); tick();
    check("pre_rst_de", {31'd0, oDE}, 32'd1);
    RST = 1'b1;
    tick();
    check("mid_rst_de",  {31'd0, oDE}, 32'd0);
    check("mid_rst_hs",  {31'd0, oH_SYNC}, 32'd1);
    check("mid_rst_rgb", {20'd0, oR, oG, oB}, 32'd0);
    check("mid_rst_cnt", {16'd0, oFRAME_CNT}, 32'd0);
    RST = 1'b0; iDE = 1'b0; iH_SYNC = 1'b1;
    frame();
    check("post_rst_cnt", {16'd0, oFRAME_CNT}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
